// File: rtl/acl2_pkg.sv
// Shared types and constants for the ADXL362 (Pmod ACL2) sample poller.
package acl2_pkg;

    typedef enum logic [2:0] {
        StSync,
        StWaitPeriod,
        StIssue,
        StWaitStart,
        StWaitDone,
        StDrain
    } state_e;

    localparam logic RwRead  = 1'b0;
    localparam logic RwWrite = 1'b1;

    localparam logic [7:0] OpRead  = 8'h0B;
    localparam logic [7:0] OpWrite = 8'h0A;

    localparam int unsigned SampleW = 8;

endpackage

// File: rtl/acl2_sample_poller_if.sv
// Poller <-> spi_controller handshake: start pulse and direction out, CS and read data back.
interface acl2_sample_poller_if;
    import acl2_pkg::*;

    logic               SPI_CS;
    logic [SampleW-1:0] SPI_DATA;
    logic               SPI_READY;
    logic               SPI_RW;

    modport master (
        output SPI_READY,
        output SPI_RW,
        input  SPI_CS,
        input  SPI_DATA
    );

    modport slave (
        input  SPI_READY,
        input  SPI_RW,
        output SPI_CS,
        output SPI_DATA
    );

endinterface

// File: rtl/sample_averager.sv
// Running mean of the last 2^AVG_LOG2 signed samples; AVG follows one cycle after the window update.
module sample_averager
    import acl2_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [SampleW-1:0] SAMPLE,
    input  logic               SAMPLE_VALID,
    output logic [SampleW-1:0] AVG,
    output logic               AVG_VALID
);

    localparam int unsigned Depth = 1 << AVG_LOG2;
    localparam int unsigned SumW  = SampleW + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FillFull = (AVG_LOG2 + 1)'(Depth);

    logic [SampleW-1:0]     win_q [Depth];
    logic [AVG_LOG2-1:0]    ptr_q;
    logic [AVG_LOG2:0]      fill_q;
    logic signed [SumW-1:0] sum_q;
    logic signed [SumW-1:0] sum_d;
    logic signed [SumW-1:0] mean;
    logic [SampleW-1:0]     oldest;
    logic                   upd_q;
    logic [SampleW-1:0]     avg_q;
    logic                   avg_valid_q;

    // The sum carries AVG_LOG2 guard bits, so add-new/drop-oldest can never overflow.
    always_comb begin
        oldest = win_q[ptr_q];
        sum_d  = sum_q + {{AVG_LOG2{SAMPLE[SampleW-1]}}, SAMPLE}
                       - {{AVG_LOG2{oldest[SampleW-1]}}, oldest};
        mean   = sum_q >>> AVG_LOG2;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(Depth); i++) begin
                win_q[i] <= '0;
            end
            ptr_q       <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            upd_q       <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            upd_q       <= SAMPLE_VALID;
            avg_valid_q <= 1'b0;
            if (SAMPLE_VALID) begin
                win_q[ptr_q] <= SAMPLE;
                ptr_q        <= ptr_q + AVG_LOG2'(1);
                sum_q        <= sum_d;
                if (fill_q != FillFull) begin
                    fill_q <= fill_q + (AVG_LOG2 + 1)'(1);
                end
            end
            if (upd_q) begin
                avg_q       <= mean[SampleW-1:0];
                avg_valid_q <= (fill_q == FillFull);
            end
        end
    end

    assign AVG       = avg_q;
    assign AVG_VALID = avg_valid_q;

endmodule

// File: rtl/acl2_sample_poller.sv
// Periodically starts spi_controller reads, captures the returned byte and feeds the averager.
module acl2_sample_poller
    import acl2_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 1_000_000,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned TIMEOUT     = 131_072
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      ENABLE,
    acl2_sample_poller_if.master      spi,
    output logic [SampleW-1:0]        SAMPLE,
    output logic                      SAMPLE_VALID,
    output logic [SampleW-1:0]        AVG,
    output logic                      AVG_VALID,
    output logic                      TIMEOUT_ERR
);

    localparam int unsigned PeriodW = $clog2(POLL_PERIOD + 1);
    localparam int unsigned ToW     = $clog2(TIMEOUT + 1);
    localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(POLL_PERIOD - 1);
    localparam logic [ToW-1:0]     ToLast     = ToW'(TIMEOUT - 1);

    state_e             state_q;
    logic               cs_q;
    logic [PeriodW-1:0] period_q;
    logic [ToW-1:0]     to_q;
    logic [SampleW-1:0] shadow_q;
    logic [SampleW-1:0] sample_q;
    logic               sample_valid_q;
    logic               ready_q;
    logic               err_q;

    logic cs_rise;
    logic timed_out;
    logic period_done;
    logic emit;

    always_comb begin
        cs_rise     = spi.SPI_CS && !cs_q;
        timed_out   = (to_q == ToLast);
        period_done = (period_q >= PeriodLast);
        emit        = (state_q == StWaitDone) && cs_rise && ENABLE;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q        <= StSync;
            cs_q           <= 1'b0;
            period_q       <= '0;
            to_q           <= '0;
            shadow_q       <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            ready_q        <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            cs_q           <= spi.SPI_CS;
            ready_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            if (period_q < PeriodLast) period_q <= period_q + PeriodW'(1);
            if (to_q < ToLast) to_q <= to_q + ToW'(1);
            if (!ENABLE) err_q <= 1'b0;
            // The controller zeroes its data as CS rises, so keep the last value seen with CS low.
            if ((state_q == StWaitStart || state_q == StWaitDone) && !spi.SPI_CS) begin
                shadow_q <= spi.SPI_DATA;
            end

            unique case (state_q)
                StSync: begin
                    // Saturate so the first poll after sync goes out straight away.
                    period_q <= PeriodLast;
                    if (spi.SPI_CS && cs_q && ENABLE) state_q <= StWaitPeriod;
                end
                StWaitPeriod: begin
                    if (!ENABLE) begin
                        state_q <= StSync;
                    end else if (period_done && spi.SPI_CS) begin
                        state_q <= StIssue;
                        ready_q <= 1'b1;
                    end
                end
                StIssue: begin
                    period_q <= PeriodW'(1);
                    to_q     <= ToW'(1);
                    state_q  <= StWaitStart;
                end
                StWaitStart: begin
                    if (!ENABLE) begin
                        state_q <= StDrain;
                    end else if (timed_out) begin
                        err_q   <= 1'b1;
                        state_q <= StSync;
                    end else if (!spi.SPI_CS) begin
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (cs_rise) begin
                        state_q <= ENABLE ? StWaitPeriod : StSync;
                        if (emit) begin
                            sample_q       <= shadow_q;
                            sample_valid_q <= 1'b1;
                        end
                    end else if (!ENABLE) begin
                        state_q <= StDrain;
                    end else if (timed_out) begin
                        err_q   <= 1'b1;
                        state_q <= StSync;
                    end
                end
                StDrain: begin
                    if (cs_rise || timed_out) state_q <= StSync;
                end
                default: state_q <= StSync;
            endcase
        end
    end

    assign spi.SPI_READY = ready_q;
    assign spi.SPI_RW    = RwRead;
    assign SAMPLE        = sample_q;
    assign SAMPLE_VALID  = sample_valid_q;
    assign TIMEOUT_ERR   = err_q;

    // Fed from the pre-register sample so the window updates on the same edge as SAMPLE.
    sample_averager #(
        .AVG_LOG2(AVG_LOG2)
    ) u_averager (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .SAMPLE      (shadow_q),
        .SAMPLE_VALID(emit),
        .AVG         (AVG),
        .AVG_VALID   (AVG_VALID)
    );

endmodule

// File: tb/tb_acl2_sample_poller.sv
// Directed bench: behavioural spi_controller model plus a cycle-stamped output monitor.
module tb_acl2_sample_poller;
    import acl2_pkg::*;

    localparam int unsigned PollPeriod = 100;
    localparam int unsigned AvgLog2    = 2;
    localparam int unsigned Timeout    = 60;
    localparam int          TxnLen     = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] sample;
    logic       sample_valid;
    logic [7:0] avg;
    logic       avg_valid;
    logic       timeout_err;

    acl2_sample_poller_if spi_bus ();

    acl2_sample_poller #(
        .POLL_PERIOD(PollPeriod),
        .AVG_LOG2   (AvgLog2),
        .TIMEOUT    (Timeout)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .ENABLE      (enable),
        .spi         (spi_bus.master),
        .SAMPLE      (sample),
        .SAMPLE_VALID(sample_valid),
        .AVG         (avg),
        .AVG_VALID   (avg_valid),
        .TIMEOUT_ERR (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model: CS low for TxnLen cycles after READY, data valid late, zeroed on CS rise.
    logic [7:0] txn_q[$];
    bit         hold = 1'b0;
    int         rise_cyc = 0;

    initial begin : ctrl_model
        logic [7:0] v;
        spi_bus.SPI_CS   = 1'b1;
        spi_bus.SPI_DATA = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_bus.SPI_READY === 1'b1) begin
                if (txn_q.size() > 0) v = txn_q.pop_front();
                else v = 8'h55;
                @(negedge clk);
                spi_bus.SPI_CS   = 1'b0;
                spi_bus.SPI_DATA = 8'hA5;
                for (int i = 1; i < TxnLen; i++) begin
                    @(negedge clk);
                    if (i >= TxnLen - 8) spi_bus.SPI_DATA = v;
                end
                while (hold) @(negedge clk);
                @(negedge clk);
                spi_bus.SPI_CS   = 1'b1;
                spi_bus.SPI_DATA = 8'h00;
                rise_cyc         = cyc;
            end
        end
    end

    int         ready_cnt = 0, last_ready_cyc = 0;
    int         sv_cnt = 0, last_sv_cyc = 0;
    int         av_cnt = 0, last_av_cyc = 0;
    logic [7:0] last_sample = 8'h00, last_avg = 8'h00;
    int         viol_dbl = 0, viol_cs = 0, viol_rw = 0;
    logic       prev_ready = 1'b0;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (spi_bus.SPI_READY === 1'b1) begin
                ready_cnt++;
                last_ready_cyc = cyc;
                if (prev_ready) viol_dbl++;
                if (spi_bus.SPI_CS !== 1'b1) viol_cs++;
            end
            prev_ready = (spi_bus.SPI_READY === 1'b1);
            if (spi_bus.SPI_RW !== 1'b0) viol_rw++;
            if (sample_valid === 1'b1) begin
                sv_cnt++;
                last_sv_cyc = cyc;
                last_sample = sample;
            end
            if (avg_valid === 1'b1) begin
                av_cnt++;
                last_av_cyc = cyc;
                last_avg    = avg;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        int start = ready_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ready_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sample(input int budget, output bit ok);
        int start = sv_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sv_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [7:0] s3_vals [9] = '{8'h04, 8'h08, 8'hFC, 8'h08, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
    logic [7:0] s3_avg  [9] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'hE3, 8'hC1, 8'hA2, 8'h80, 8'hA0};

    initial begin : main
        bit ok;
        int t0, sv0, r0, av0, rel;

        // 1: reset state and first poll after sync
        rst_n  = 1'b0;
        enable = 1'b1;
        txn_q.push_back(8'h12);
        repeat (3) tick();
        check_eq("rst_sample", 32'(sample), 32'h0);
        check_eq("rst_avg", 32'(avg), 32'h0);
        check_eq("rst_flags", {28'h0, sample_valid, avg_valid, timeout_err, spi_bus.SPI_READY}, 32'h0);
        check_eq("rst_rw", 32'(spi_bus.SPI_RW), 32'h0);
        rel   = cyc;
        rst_n = 1'b1;
        wait_ready(20, ok);
        check_eq("first_ready_seen", 32'(ok), 32'h1);
        check_eq("first_ready_cyc", 32'(last_ready_cyc - rel), 32'd3);
        t0 = last_ready_cyc;
        tick();
        check_eq("ready_width", 32'(spi_bus.SPI_READY), 32'h0);

        // 2: capture through the CS-rise zeroing
        sv0 = sv_cnt;
        wait_sample(100, ok);
        check_eq("s2_sample_seen", 32'(ok), 32'h1);
        check_eq("s2_sample", 32'(last_sample), 32'h12);
        check_eq("s2_sv_timing", 32'(last_sv_cyc - rise_cyc), 32'd1);
        repeat (5) tick();
        check_eq("s2_sv_once", 32'(sv_cnt - sv0), 32'd1);
        wait_ready(150, ok);
        check_eq("poll_spacing", 32'(last_ready_cyc - t0), 32'(PollPeriod));
        wait_sample(100, ok);

        // 3: averaging window fill, wrap and floor rounding
        rst_n = 1'b0;
        for (int i = 0; i < 9; i++) txn_q.push_back(s3_vals[i]);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            av0 = av_cnt;
            wait_sample(200, ok);
            check_eq($sformatf("s3_seen_%0d", i), 32'(ok), 32'h1);
            check_eq($sformatf("s3_sample_%0d", i), 32'(last_sample), 32'(s3_vals[i]));
            tick();
            if (i < 3) begin
                check_eq($sformatf("s3_no_avg_%0d", i), 32'(av_cnt - av0), 32'd0);
            end else begin
                check_eq($sformatf("s3_avg_valid_%0d", i), 32'(av_cnt - av0), 32'd1);
                check_eq($sformatf("s3_avg_%0d", i), 32'(last_avg), 32'(s3_avg[i]));
                check_eq($sformatf("s3_avg_timing_%0d", i), 32'(last_av_cyc - last_sv_cyc), 32'd1);
            end
        end

        // 4: stalled controller
        wait_ready(200, ok);
        check_eq("s4_ready_seen", 32'(ok), 32'h1);
        t0   = last_ready_cyc;
        hold = 1'b1;
        sv0  = sv_cnt;
        r0   = ready_cnt;
        while (cyc < t0 + int'(Timeout) - 1) tick();
        check_eq("to_not_yet", 32'(timeout_err), 32'h0);
        tick();
        check_eq("to_flag", 32'(timeout_err), 32'h1);
        repeat (30) tick();
        check_eq("to_no_sample", 32'(sv_cnt - sv0), 32'd0);
        check_eq("to_no_ready", 32'(ready_cnt - r0), 32'd0);
        hold = 1'b0;
        wait_ready(100, ok);
        check_eq("to_resume_seen", 32'(ok), 32'h1);
        check_eq("to_resume_cyc", 32'(last_ready_cyc - rise_cyc), 32'd3);
        check_eq("to_sticky", 32'(timeout_err), 32'h1);
        check_eq("to_discarded", 32'(sv_cnt - sv0), 32'd0);
        wait_sample(100, ok);
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check_eq("to_clear", 32'(timeout_err), 32'h0);

        // 5: disable mid-transaction
        txn_q.push_back(8'h33);
        enable = 1'b1;
        wait_ready(20, ok);
        check_eq("s5_ready_seen", 32'(ok), 32'h1);
        sv0 = sv_cnt;
        r0  = ready_cnt;
        repeat (20) tick();
        enable = 1'b0;
        repeat (120) tick();
        check_eq("s5_no_sample", 32'(sv_cnt - sv0), 32'd0);
        check_eq("s5_no_ready", 32'(ready_cnt - r0), 32'd0);
        txn_q.push_back(8'h44);
        enable = 1'b1;
        wait_ready(20, ok);
        check_eq("s5_resume", 32'(ok), 32'h1);
        wait_sample(100, ok);
        check_eq("s5_sample", 32'(last_sample), 32'h44);

        // 6: reset mid-transaction while CS stays low
        wait_ready(200, ok);
        check_eq("s6_ready_seen", 32'(ok), 32'h1);
        hold = 1'b1;
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        check_eq("s6_rst_sample", 32'(sample), 32'h0);
        check_eq("s6_rst_avg", 32'(avg), 32'h0);
        check_eq("s6_rst_flags", {28'h0, sample_valid, avg_valid, timeout_err, spi_bus.SPI_READY}, 32'h0);
        rst_n = 1'b1;
        r0    = ready_cnt;
        repeat (20) tick();
        check_eq("s6_no_ready", 32'(ready_cnt - r0), 32'd0);
        hold = 1'b0;
        wait_ready(50, ok);
        check_eq("s6_resume_seen", 32'(ok), 32'h1);
        check_eq("s6_resume_cyc", 32'(last_ready_cyc - rise_cyc), 32'd3);

        check_eq("ready_double", 32'(viol_dbl), 32'd0);
        check_eq("ready_cs_low", 32'(viol_cs), 32'd0);
        check_eq("rw_nonzero", 32'(viol_rw), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
